// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer sharing one memory port between fetch and load/store.
// Optional memory watchdog is enabled by defining MEM_WATCHDOG_EN.
module multicycle_sequencer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             Branch,
    input  logic [1:0]       RegSrc,
    input  logic             BranchTaken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_data,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             RegFileWE,
    output logic             instr_retired,
    output logic [CNT_W-1:0] retired_count,
    output logic             halted,
    output logic [2:0]       state_o,
    output logic             bus_err
);

    typedef enum logic [2:0] {
        S_HALT    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retiredCount_q;
    logic             memOp;

    assign memOp = MemRead | MemWrite;

`ifdef MEM_WATCHDOG_EN
    localparam int             WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wdCnt_q, wdCnt_d;
    logic            busErr_q;
    logic            waiting;
    logic            wdExpire;

    assign waiting  = mem_req & ~mem_ready;
    assign wdExpire = waiting & (wdCnt_q == WD_LAST);
    // Any cycle that is not a stalled request restarts the count, so each request starts from zero.
    assign wdCnt_d  = waiting ? wdCnt_q + WD_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdCnt_q  <= '0;
            busErr_q <= 1'b0;
        end else begin
            wdCnt_q  <= wdCnt_d;
            busErr_q <= busErr_q | wdExpire;
        end
    end

    assign bus_err = busErr_q;
`else
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_HALT;
            retiredCount_q <= '0;
        end else begin
            state_q <= state_d;
            if (instr_retired) begin
                retiredCount_q <= retiredCount_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALT: begin
`ifdef MEM_WATCHDOG_EN
                if (run && !busErr_q) state_d = S_FETCH;
`else
                if (run) state_d = S_FETCH;
`endif
            end
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (memOp)        state_d = S_MEM;
                else if (!Branch) state_d = S_WB;
            end
            S_MEM:     if (mem_ready && !MemWrite) state_d = S_WB;
            S_WB:      state_d = S_WB;
            default:   state_d = S_HALT;
        endcase
        // run is only honoured at an instruction boundary.
        if (instr_retired) begin
            state_d = run ? S_FETCH : S_HALT;
        end
`ifdef MEM_WATCHDOG_EN
        if (wdExpire) begin
            state_d = S_HALT;
        end
`endif
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel_data  = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCSrc         = 1'b0;
        RegFileWE     = 1'b0;
        instr_retired = 1'b0;
        halted        = 1'b0;
        unique case (state_q)
            S_HALT: halted = 1'b1;
            S_FETCH: begin
                mem_req = 1'b1;
                IRWrite = mem_ready;
            end
            S_EXECUTE: begin
                if (Branch && !memOp) begin
                    instr_retired = 1'b1;
                    PCWrite       = 1'b1;
                    PCSrc         = BranchTaken;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = MemWrite;
                if (mem_ready && MemWrite) begin
                    instr_retired = 1'b1;
                    PCWrite       = 1'b1;
                end
            end
            S_WB: begin
                RegFileWE     = RegWrite;
                instr_retired = 1'b1;
                PCWrite       = 1'b1;
                PCSrc         = (RegSrc == 2'd3);
            end
            default: ;
        endcase
    end

    assign state_o       = state_q;
    assign retired_count = retiredCount_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed instruction table, randomized
// instruction stream against a cycle-list model, and hand-written corner sequences.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        RegWrite = 1'b0;
    logic        Branch = 1'b0;
    logic [1:0]  RegSrc = 2'd0;
    logic        BranchTaken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_sel_data, IRWrite, PCWrite, PCSrc, RegFileWE;
    logic        instr_retired, halted, bus_err;
    logic [31:0] retired_count;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .Branch(Branch),
        .RegSrc(RegSrc), .BranchTaken(BranchTaken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegFileWE(RegFileWE),
        .instr_retired(instr_retired), .retired_count(retired_count),
        .halted(halted), .state_o(state_o), .bus_err(bus_err)
    );

    typedef struct packed {
        logic [2:0] st;
        logic halted, req, we, sel, ir, pcw, pcs, rfwe, ret, berr;
    } outT;

    typedef struct {
        logic rdy;
        outT  exp;
    } cycT;

    typedef struct {
        logic       memRead, memWrite, regWrite, branch;
        logic [1:0] regSrc;
        logic       taken;
    } insT;

    typedef struct {
        string name;
        insT   ins;
        int    fetchWait;
        int    memWait;
        int    expCycles;
        logic  expPcSrc;
        logic  expRegWe;
    } vecT;

    int  checks = 0;
    int  errors = 0;
    int  modelCount = 0;
    cycT expQ[$];
    vecT vecs[9];

    function automatic outT sampleOut();
        outT o;
        o = {state_o, halted, mem_req, mem_we, mem_sel_data, IRWrite, PCWrite, PCSrc,
             RegFileWE, instr_retired, bus_err};
        return o;
    endfunction

    function automatic outT base(logic [2:0] st);
        outT o;
        o = '0;
        o.st = st;
        o.halted = (st == 3'd0);
        return o;
    endfunction

    function automatic insT mkIns(logic rd, logic wr, logic rw, logic br, logic [1:0] rs, logic tk);
        insT i;
        i.memRead = rd; i.memWrite = wr; i.regWrite = rw;
        i.branch = br; i.regSrc = rs; i.taken = tk;
        return i;
    endfunction

    function automatic void push(logic rdy, outT o);
        cycT c;
        c.rdy = rdy;
        c.exp = o;
        expQ.push_back(c);
    endfunction

    // Expected cycle list of one instruction, built from the per-phase latency rules.
    function automatic void modelInstr(insT ins, int fw, int mw);
        outT o;
        logic memOp;
        memOp = ins.memRead | ins.memWrite;
        for (int i = 0; i < fw; i++) begin
            o = base(3'd1); o.req = 1'b1;
            push(1'b0, o);
        end
        o = base(3'd1); o.req = 1'b1; o.ir = 1'b1;
        push(1'b1, o);
        push(1'($urandom_range(0, 1)), base(3'd2));
        o = base(3'd3);
        if (ins.branch && !memOp) begin
            o.pcw = 1'b1; o.pcs = ins.taken; o.ret = 1'b1;
        end
        push(1'($urandom_range(0, 1)), o);
        if (memOp) begin
            for (int i = 0; i <= mw; i++) begin
                o = base(3'd4); o.req = 1'b1; o.sel = 1'b1; o.we = ins.memWrite;
                if (i == mw && ins.memWrite) begin
                    o.pcw = 1'b1; o.ret = 1'b1;
                end
                push(i == mw, o);
            end
        end
        if (!(ins.branch && !memOp) && !ins.memWrite) begin
            o = base(3'd5); o.rfwe = ins.regWrite; o.pcw = 1'b1;
            o.pcs = (ins.regSrc == 2'd3); o.ret = 1'b1;
            push(1'($urandom_range(0, 1)), o);
        end
        modelCount++;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(insT ins);
        MemRead = ins.memRead; MemWrite = ins.memWrite; RegWrite = ins.regWrite;
        Branch = ins.branch; RegSrc = ins.regSrc; BranchTaken = ins.taken;
    endtask

    task automatic stepCycle(string name);
        cycT c;
        if (expQ.size() == 0) begin
            checkOutput({name, " queue empty"}, 32'd1, 32'd0);
        end else begin
            c = expQ.pop_front();
            mem_ready = c.rdy;
            @(negedge clk);
            checkOutput(name, 32'(sampleOut()), 32'(c.exp));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drainQueue(string name);
        while (expQ.size() > 0) stepCycle(name);
    endtask

    task automatic runVector(vecT v);
        int   cyc;
        logic done, sawWe, pcs;
        cyc = 0; done = 1'b0; sawWe = 1'b0; pcs = 1'b0;
        applyStimulus(v.ins);
        while (!done && cyc < 40) begin
            mem_ready = !((cyc < v.fetchWait) ||
                          (cyc >= v.fetchWait + 3 && cyc < v.fetchWait + 3 + v.memWait));
            @(negedge clk);
            if (RegFileWE) sawWe = 1'b1;
            if (instr_retired) begin
                done = 1'b1;
                pcs  = PCSrc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        modelCount++;
        checkOutput({v.name, " cycles"}, 32'(cyc), 32'(v.expCycles));
        checkOutput({v.name, " PCSrc"}, 32'(pcs), 32'(v.expPcSrc));
        checkOutput({v.name, " RegFileWE"}, 32'(sawWe), 32'(v.expRegWe));
        checkOutput({v.name, " retired_count"}, retired_count, 32'(modelCount));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        outT o;
        insT ins;
        vecs[0] = '{"alu",        mkIns(0,0,1,0,2'd0,0), 0, 0, 4, 1'b0, 1'b1};
        vecs[1] = '{"jal",        mkIns(0,0,1,0,2'd3,0), 0, 0, 4, 1'b1, 1'b1};
        vecs[2] = '{"fence",      mkIns(0,0,0,0,2'd0,0), 0, 0, 4, 1'b0, 1'b0};
        vecs[3] = '{"beq taken",  mkIns(0,0,0,1,2'd0,1), 0, 0, 3, 1'b1, 1'b0};
        vecs[4] = '{"bne not",    mkIns(0,0,0,1,2'd0,0), 0, 0, 3, 1'b0, 1'b0};
        vecs[5] = '{"store",      mkIns(0,1,0,0,2'd0,0), 0, 0, 4, 1'b0, 1'b0};
        vecs[6] = '{"load",       mkIns(1,0,1,0,2'd1,0), 0, 0, 5, 1'b0, 1'b1};
        vecs[7] = '{"load wait3", mkIns(1,0,1,0,2'd1,0), 0, 3, 8, 1'b0, 1'b1};
        vecs[8] = '{"alu fwait2", mkIns(0,0,1,0,2'd1,0), 2, 0, 6, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outputs", 32'(sampleOut()), 32'(base(3'd0)));
        checkOutput("reset count", retired_count, 32'd0);

        rst_n = 1'b1;
        run   = 1'b1;
        push(1'b1, base(3'd0));
        stepCycle("halt to fetch");

        for (int i = 0; i < 9; i++) runVector(vecs[i]);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: ins = mkIns(0,0,1,0,2'($urandom_range(0, 2)),0);
                1: ins = mkIns(0,0,0,0,2'd0,0);
                2: ins = mkIns(0,0,1,0,2'd3,0);
                3: ins = mkIns(0,0,0,1,2'd0,1'($urandom_range(0, 1)));
                4: ins = mkIns(1,0,1,0,2'd1,0);
                default: ins = mkIns(0,1,0,0,2'd0,0);
            endcase
            applyStimulus(ins);
            modelInstr(ins, $urandom_range(0, 3), $urandom_range(0, 3));
            drainQueue("random cycle");
            checkOutput("random retired_count", retired_count, 32'(modelCount));
        end

        // JAL with run dropped in DECODE still completes, then halts.
        ins = mkIns(0,0,1,0,2'd3,0);
        applyStimulus(ins);
        modelInstr(ins, 0, 0);
        stepCycle("jal fetch");
        run = 1'b0;
        drainQueue("jal run drop");
        push(1'b1, base(3'd0));
        push(1'b1, base(3'd0));
        drainQueue("halt after jal");
        checkOutput("jal retired_count", retired_count, 32'(modelCount));

        // Reset asserted while a load is waiting in MEM.
        run = 1'b1;
        ins = mkIns(1,0,1,0,2'd1,0);
        applyStimulus(ins);
        push(1'b0, base(3'd0));
        modelInstr(ins, 0, 5);
        for (int i = 0; i < 5; i++) stepCycle("load to mem");
        expQ.delete();
        mem_ready = 1'b0;
        checkOutput("mid-mem req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid-mem reset state", 32'(state_o), 32'd0);
        checkOutput("mid-mem reset req", 32'(mem_req), 32'd0);
        checkOutput("mid-mem reset halted", 32'(halted), 32'd1);
        checkOutput("mid-mem reset count", retired_count, 32'd0);
        modelCount = 0;
        rst_n = 1'b1;

        // Fetch that never completes.
        push(1'b0, base(3'd0));
`ifdef MEM_WATCHDOG_EN
        for (int i = 0; i < 4; i++) begin
            o = base(3'd1); o.req = 1'b1;
            push(1'b0, o);
        end
        for (int i = 0; i < 3; i++) begin
            o = base(3'd0); o.berr = 1'b1;
            push(1'b1, o);
        end
        drainQueue("watchdog");
`else
        for (int i = 0; i < 10; i++) begin
            o = base(3'd1); o.req = 1'b1;
            push(1'b0, o);
        end
        drainQueue("stalled fetch");
`endif
        checkOutput("final count", retired_count, 32'(modelCount));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
